// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the 18-bit RAM command protocol: opcodes, widths and
// the initiator FSM state encoding.
package ram_cmd_pkg;

    localparam int CMD_W  = 18;
    localparam int WORD_W = 16;

    localparam logic [1:0] OP_ADDR_STORE = 2'b00;
    localparam logic [1:0] OP_DATA_WRITE = 2'b01;
    localparam logic [1:0] OP_READ_ADDR  = 2'b10;
    localparam logic [1:0] OP_READ_DATA  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_DATA,
        WAIT_RSP,
        DONE
    } state_t;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0]        opcode,
                                                  input logic [WORD_W-1:0] payload);
        return {opcode, payload};
    endfunction

endpackage

// File: rtl/ram_cmd_timer.sv
// Loadable down-counter that bounds how long the master waits for a read
// response; expired is high once the count has run down to zero.
module ram_cmd_timer #(
    parameter int WIDTH = 4
) (
    input  logic             sys_clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ram_cmd_master.sv
// Initiator for the RAM command port: turns single-word host requests into
// address/data command pairs and returns read data with a completion pulse.
module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int RSP_TIMEOUT = 15,
    parameter bit ADDR_CACHE  = 1'b1
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_data,
    input  logic              rsp_valid_in,
    input  logic [CMD_W-1:0]  rsp_data_in,
    output logic              done,
    output logic [WORD_W-1:0] rd_data,
    output logic              err
);

    localparam int                TMR_W     = $clog2(RSP_TIMEOUT + 1);
    localparam logic [WORD_W:0]   DEPTH_LIM = (WORD_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(RSP_TIMEOUT);

    state_t              state, state_nx;
    logic [WORD_W-1:0]   addr_q, wdata_q;
    logic [WORD_W-1:0]   wc_addr;
    logic                wc_valid;

    logic                req_ready_nx, cmd_valid_nx, done_nx, err_nx;
    logic [CMD_W-1:0]    cmd_data_nx;
    logic [WORD_W-1:0]   rd_data_nx;
    logic                accept, wc_load, tmr_load, tmr_dec, tmr_expired;
    logic                addr_oor, wc_hit;

    // The response opcode field carries no information for the master.
    logic [CMD_W-WORD_W-1:0] unused_rsp_op;
    assign unused_rsp_op = rsp_data_in[CMD_W-1:WORD_W];

    assign addr_oor = ({1'b0, req_addr} >= DEPTH_LIM);
    assign wc_hit   = ADDR_CACHE && wc_valid && (wc_addr == req_addr);

    ram_cmd_timer #(
        .WIDTH      (TMR_W)
    ) u_timer (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (TMR_LOAD),
        .dec        (tmr_dec),
        .expired    (tmr_expired)
    );

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        cmd_valid_nx = 1'b0;
        cmd_data_nx  = '0;
        done_nx      = 1'b0;
        rd_data_nx   = rd_data;
        err_nx       = err;
        accept       = 1'b0;
        wc_load      = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    rd_data_nx = '0;
                    err_nx     = 1'b0;
                    if (addr_oor) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        err_nx   = 1'b1;
                    end else if (req_write && wc_hit) begin
                        state_nx     = W_DATA;
                        cmd_valid_nx = 1'b1;
                        cmd_data_nx  = make_cmd(OP_DATA_WRITE, req_wdata);
                    end else if (req_write) begin
                        state_nx     = W_ADDR;
                        cmd_valid_nx = 1'b1;
                        cmd_data_nx  = make_cmd(OP_ADDR_STORE, req_addr);
                    end else begin
                        state_nx     = R_ADDR;
                        cmd_valid_nx = 1'b1;
                        cmd_data_nx  = make_cmd(OP_READ_ADDR, req_addr);
                    end
                end
            end
            W_ADDR: begin
                wc_load      = 1'b1;
                state_nx     = W_DATA;
                cmd_valid_nx = 1'b1;
                cmd_data_nx  = make_cmd(OP_DATA_WRITE, wdata_q);
            end
            W_DATA: begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end
            R_ADDR: begin
                state_nx     = R_DATA;
                cmd_valid_nx = 1'b1;
                cmd_data_nx  = make_cmd(OP_READ_DATA, '0);
            end
            R_DATA: begin
                tmr_load = 1'b1;
                state_nx = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_valid_in) begin
                    rd_data_nx = rsp_data_in[WORD_W-1:0];
                    state_nx   = DONE;
                    done_nx    = 1'b1;
                end else if (tmr_expired) begin
                    rd_data_nx = '0;
                    err_nx     = 1'b1;
                    state_nx   = DONE;
                    done_nx    = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so ready only rises the
        // cycle after done.
        req_ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            done      <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wc_addr   <= '0;
            wc_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            req_ready <= req_ready_nx;
            cmd_valid <= cmd_valid_nx;
            cmd_data  <= cmd_data_nx;
            done      <= done_nx;
            rd_data   <= rd_data_nx;
            err       <= err_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // The slave's write pointer now matches addr_q.
            if (wc_load) begin
                wc_addr  <= addr_q;
                wc_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master with a behavioural RAM command slave.
module tb_ram_cmd_master;
    import ram_cmd_pkg::*;

    logic        sys_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, cmd_valid, done, err;
    logic [17:0] cmd_data;
    logic [15:0] rd_data;
    logic        rsp_valid_in;
    logic [17:0] rsp_data_in;

    logic        ram_mute = 1'b0;
    logic        ram_tx_valid;
    logic [17:0] ram_dout;
    logic [15:0] ram_mem [0:511];
    logic [8:0]  ram_wp, ram_rp;

    logic [17:0] cmd_log [$];
    int          zero_viol = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 sys_clock = ~sys_clock;

    ram_cmd_master #(
        .DEPTH        (512),
        .RSP_TIMEOUT  (15),
        .ADDR_CACHE   (1'b1)
    ) dut (
        .sys_clock    (sys_clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .rsp_valid_in (rsp_valid_in),
        .rsp_data_in  (rsp_data_in),
        .done         (done),
        .rd_data      (rd_data),
        .err          (err)
    );

    // Behavioural RAM slave: sticky tx_valid, data_out zeroed on idle cycles.
    always @(posedge sys_clock) begin
        if (!reset_n) begin
            ram_wp       <= '0;
            ram_rp       <= '0;
            ram_tx_valid <= 1'b0;
            ram_dout     <= '0;
        end else if (cmd_valid) begin
            case (cmd_data[17:16])
                OP_ADDR_STORE: ram_wp <= cmd_data[8:0];
                OP_DATA_WRITE: ram_mem[ram_wp] <= cmd_data[15:0];
                OP_READ_ADDR: begin
                    ram_rp       <= cmd_data[8:0];
                    ram_tx_valid <= 1'b0;
                end
                default: begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= {2'b00, ram_mem[ram_rp]};
                end
            endcase
        end else begin
            ram_dout <= '0;
        end
    end

    assign rsp_valid_in = ram_tx_valid & ~ram_mute;
    assign rsp_data_in  = ram_dout;

    always @(posedge sys_clock) begin
        if (reset_n && cmd_valid) cmd_log.push_back(cmd_data);
        if (!cmd_valid && cmd_data != '0) zero_viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One request; lat counts cycles from the accept cycle to the done cycle.
    task automatic send(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat);
        int guard;
        @(negedge sys_clock);
        cmd_log.delete();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge sys_clock);
            guard++;
        end
        @(negedge sys_clock);
        req_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge sys_clock);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic check_log(input string name, input logic [17:0] exp_cmds [$]);
        logic ok;
        ok = (cmd_log.size() == exp_cmds.size());
        if (ok) foreach (exp_cmds[i]) if (cmd_log[i] !== exp_cmds[i]) ok = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: command stream %p, required %p", name, cmd_log, exp_cmds);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clock);
        checks++;
        if ({req_ready, cmd_valid, cmd_data, done, rd_data, err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b cmd_valid=%b cmd_data=%h done=%b rd_data=%h err=%b, required all 0",
                     req_ready, cmd_valid, cmd_data, done, rd_data, err);
        end
        reset_n = 1'b1;
        @(negedge sys_clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_write_read;
        int lat;
        send(1'b1, 16'h0005, 16'hBEEF, lat);
        check_log("wr5_cmds", '{{OP_ADDR_STORE, 16'h0005}, {OP_DATA_WRITE, 16'hBEEF}});
        checks++;
        if (lat !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL wr5_latency: latency=%0d err=%b, required 3 and 0", lat, err);
        end
        send(1'b0, 16'h0005, 16'h0000, lat);
        check_log("rd5_cmds", '{{OP_READ_ADDR, 16'h0005}, {OP_READ_DATA, 16'h0000}});
        checks++;
        if (lat !== 4 || rd_data !== 16'hBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL rd5: latency=%0d rd_data=%h err=%b, required 4 BEEF 0", lat, rd_data, err);
        end
    endtask

    task automatic test_addr_cache;
        int lat;
        send(1'b1, 16'h0010, 16'h1111, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL cache_miss_latency: latency=%0d, required 3", lat);
        end
        send(1'b1, 16'h0010, 16'h2222, lat);
        check_log("cache_hit_cmds", '{{OP_DATA_WRITE, 16'h2222}});
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL cache_hit_latency: latency=%0d, required 2", lat);
        end
        send(1'b0, 16'h0010, 16'h0000, lat);
        checks++;
        if (lat !== 4 || rd_data !== 16'h2222 || err !== 1'b0) begin
            errors++;
            $display("FAIL cache_readback: latency=%0d rd_data=%h err=%b, required 4 2222 0", lat, rd_data, err);
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        send(1'b0, 16'h0200, 16'h0000, lat);
        check_log("oor_rd_cmds", '{});
        checks++;
        if (lat !== 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: latency=%0d err=%b, required 1 and 1", lat, err);
        end
        send(1'b1, 16'hFFFF, 16'h1234, lat);
        check_log("oor_wr_cmds", '{});
        checks++;
        if (lat !== 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_write: latency=%0d err=%b, required 1 and 1", lat, err);
        end
        send(1'b1, 16'h01FF, 16'hA5A5, lat);
        check_log("top_word_cmds", '{{OP_ADDR_STORE, 16'h01FF}, {OP_DATA_WRITE, 16'hA5A5}});
        checks++;
        if (lat !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL top_word_write: latency=%0d err=%b, required 3 and 0", lat, err);
        end
        send(1'b0, 16'h01FF, 16'h0000, lat);
        checks++;
        if (lat !== 4 || rd_data !== 16'hA5A5 || err !== 1'b0) begin
            errors++;
            $display("FAIL top_word_read: latency=%0d rd_data=%h err=%b, required 4 A5A5 0", lat, rd_data, err);
        end
    endtask

    task automatic test_timeout;
        int lat;
        ram_mute = 1'b1;
        send(1'b0, 16'h0005, 16'h0000, lat);
        ram_mute = 1'b0;
        check_log("timeout_cmds", '{{OP_READ_ADDR, 16'h0005}, {OP_READ_DATA, 16'h0000}});
        checks++;
        if (lat !== 19 || rd_data !== 16'h0000 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: latency=%0d rd_data=%h err=%b, required 19 0000 1", lat, rd_data, err);
        end
    endtask

    task automatic test_reset_mid;
        int  lat;
        int  guard;
        logic done_seen;
        @(negedge sys_clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'h3333;
        guard = 0;
        while (!(cmd_valid === 1'b1 && cmd_data[17:16] === OP_DATA_WRITE) && guard < 20) begin
            @(negedge sys_clock);
            guard++;
            req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (cmd_data !== {OP_DATA_WRITE, 16'h3333}) begin
            errors++;
            $display("FAIL mid_wdata_cmd: cmd_data=%h, required %h", cmd_data, {OP_DATA_WRITE, 16'h3333});
        end
        reset_n = 1'b0;
        @(negedge sys_clock);
        reset_n = 1'b1;
        checks++;
        if ({done, cmd_valid, req_ready} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_state: done=%b cmd_valid=%b req_ready=%b, required 000", done, cmd_valid, req_ready);
        end
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge sys_clock);
            if (done === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done seen=%b, required 0", done_seen);
        end
        send(1'b1, 16'h0010, 16'h4444, lat);
        check_log("post_reset_cmds", '{{OP_ADDR_STORE, 16'h0010}, {OP_DATA_WRITE, 16'h4444}});
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL post_reset_latency: latency=%0d, required 3", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs [2] = '{16'h0005, 16'h0010};
        logic [15:0] exp_d [2] = '{16'hBEEF, 16'h4444};
        int   guard;
        int   lat;
        logic ready_leak;
        @(negedge sys_clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addrs[0];
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge sys_clock);
            guard++;
        end
        for (int i = 0; i < 2; i++) begin
            lat = 0;
            ready_leak = 1'b0;
            do begin
                @(negedge sys_clock);
                lat++;
                if (i == 0) req_addr = addrs[1];
                if (req_ready !== 1'b0) ready_leak = 1'b1;
            end while (done !== 1'b1 && lat < 40);
            checks++;
            if (lat !== 4 || rd_data !== exp_d[i] || err !== 1'b0 || ready_leak !== 1'b0) begin
                errors++;
                $display("FAIL b2b_read%0d: latency=%0d rd_data=%h err=%b ready_leak=%b, required 4 %h 0 0",
                         i, lat, rd_data, err, ready_leak, exp_d[i]);
            end
            @(negedge sys_clock);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: req_ready=%b, required 1", i, req_ready);
            end
            if (i == 1) req_valid = 1'b0;
        end
    endtask

    task automatic test_idle_bus;
        checks++;
        if (zero_viol !== 0) begin
            errors++;
            $display("FAIL idle_cmd_data: %0d cycles with nonzero cmd_data while cmd_valid=0, required 0", zero_viol);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_cache();
        test_out_of_range();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_idle_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_cmd_master.md
# ram_cmd_master

Initiator for the 18-bit RAM command protocol: accepts single-word write/read requests from a host, serialises each into the two-command sequence the 1 kB RAM slave expects (address command, then data command), and returns read data with a completion pulse. Sits between the host/SPI-master logic and the RAM command port, driving the RAM's `rx_valid`/`data_in` and consuming its `tx_valid`/`data_out`.

## Interface
- `DEPTH`, 512: RAM words. Requests with `req_addr >= DEPTH` are rejected.
- `RSP_TIMEOUT`, 15: maximum cycles spent in `WAIT_RSP` before a read completes with an error.
- `ADDR_CACHE`, 1: when 1, omit `ADDR_STORE` if the write address equals the cached write pointer.
- `sys_clock` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: host request present.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: word address.
- `req_wdata` in 16: write data.
- `cmd_valid` out 1: command strobe; connects to the RAM's `rx_valid`.
- `cmd_data` out 18: `{opcode[1:0], payload[15:0]}`; connects to the RAM's `data_in`.
- `rsp_valid_in` in 1: the RAM's `tx_valid`.
- `rsp_data_in` in 18: the RAM's `data_out`.
- `done` out 1: one-cycle completion pulse for every accepted request.
- `rd_data` out 16: read data, valid when `done` is high for a read.
- `err` out 1: qualifies `done`. Set for an out-of-range address or a read timeout.

## Operation
- Opcodes: `ADDR_STORE`=00, `DATA_WRITE`=01, `READ_ADDR`=10, `READ_DATA`=11.
- FSM states: `IDLE`, `W_ADDR`, `W_DATA`, `R_ADDR`, `R_DATA`, `WAIT_RSP`, `DONE`.
- `IDLE`:
  - `req_ready`=1.
  - On accept, register `req_write`, `req_addr` and `req_wdata`.
  - Out-of-range address: go to `DONE` with `err`=1. No command is issued.
  - Write: go to `W_ADDR`. If `ADDR_CACHE` is set and the write cache is valid and equal to the address, go to `W_DATA` instead.
  - Read: go to `R_ADDR`.
- `W_ADDR`:
  - Drive `cmd_valid`=1 with `{00, addr}`.
  - Load the write cache and set it valid.
  - Go to `W_DATA`.
- `W_DATA`:
  - Drive `cmd_valid`=1 with `{01, wdata}`.
  - Go to `DONE`.
- `R_ADDR`:
  - Drive `cmd_valid`=1 with `{10, addr}`. This command also clears the slave's sticky `tx_valid`.
  - Go to `R_DATA`.
- `R_DATA`:
  - Drive `cmd_valid`=1 with `{11, 16'h0}`.
  - Clear the timeout counter and go to `WAIT_RSP`.
- `WAIT_RSP`:
  - If `rsp_valid_in`=1, capture `rsp_data_in[15:0]` into `rd_data` and go to `DONE`.
  - Otherwise increment the counter. When the counter reaches `RSP_TIMEOUT`, set `rd_data`=0 and `err`=1, then go to `DONE`.
- `DONE`:
  - Assert `done` for one cycle, then return to `IDLE`.
  - `rd_data` and `err` hold until the next accept.
- The read cache is not used: `READ_ADDR` is always sent because it is needed to clear `tx_valid`.
- `cmd_data` is 0 whenever `cmd_valid`=0.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 in `IDLE`. `cmd_valid`=0, `cmd_data`=0, `done`=0, `rd_data`=0, `err`=0, FSM=`IDLE`, write cache invalid, counter=0.
- All outputs are registered. `cmd_valid` is high for exactly one cycle per command, and commands are issued back-to-back.
- Write latency, accept to `done`: 3 cycles, or 2 cycles with a cache hit.
- Read latency, direct connection: the RAM returns `tx_valid` one cycle after `READ_DATA`, so accept to `done` is 4 cycles.
- `rsp_data_in` must be captured in the first `WAIT_RSP` cycle with `rsp_valid_in`=1. The RAM zeroes `data_out` on the following idle cycle.
- `rsp_valid_in` outside `WAIT_RSP` is ignored.
- The counter width is `$clog2(RSP_TIMEOUT+1)`. A timeout gives `done` at cycle 3+`RSP_TIMEOUT`+1 after accept.
- `reset_n` low mid-sequence:
  - Abort the sequence immediately; no `done` is produced.
  - Invalidate the write cache, since the RAM pointers also reset to 0.
- A new request is not accepted in the same cycle as `done`. `req_ready` rises the cycle after.

## Structure
- Shared package `ram_cmd_pkg` holds:
  - the opcode localparams, reused by the RAM slave;
  - the FSM state enum;
  - the constants `CMD_W`=18 and `WORD_W`=16.
- One sub-module, `ram_cmd_timer`: a loadable down-counter with a `expired` flag, used for `WAIT_RSP`.
- The FSM and datapath are flat in `ram_cmd_master`.

## Test plan
- Write 0x0005←0xBEEF, then read 0x0005, with the actual RAM slave attached:
  - command stream `{00,0005}`, `{01,BEEF}`, `{10,0005}`, `{11,0000}`;
  - `rd_data`=0xBEEF with `err`=0, `done` 4 cycles after the read accept.
- Two writes to 0x0010 (0x1111, then 0x2222) with `ADDR_CACHE`=1:
  - the second write issues only `{01,2222}`, and `done` comes 2 cycles after accept;
  - a subsequent read returns 0x2222.
- Read 0x0200 with `DEPTH`=512: no `cmd_valid` ever; `done`=1 with `err`=1 one cycle after accept.
- RAM stubbed so it never raises `tx_valid`, `RSP_TIMEOUT`=15: `done` with `err`=1 and `rd_data`=0 at cycle 19 after accept.
- Pulse `reset_n` low during `W_DATA`, then write 0x0010 again with `ADDR_CACHE`=1: `{00,0010}` is re-issued because the cache was invalidated.
- Back-to-back reads with `req_valid` held high: `req_ready` is low between the accept and `done`; each read returns the correct word.
